uart_baud_tick_gen: RTL and testbench
=====================================

Name: uart_baud_tick_gen

Overview:
- Parametrised fractional baud-tick generator for the UART TX/RX paths. It replaces the integer-divide sample-enable generator.
- A phase accumulator (NCO) produces an oversampled RX sample tick with no long-term rounding drift.
- It also produces a 1x TX bit tick and a mid-bit strobe for the receiver.
- Runtime rate comes from the 8-entry baud table or from a custom increment. A restart input lets the receiver realign to a start-bit edge.

Parameters:
- CLK_FREQ_HZ, 50000000, input clock frequency.
- OVERSAMPLE, 16, sample ticks per bit; power of two, 4..64.
- ACC_WIDTH, 24, phase accumulator width; sets the fractional resolution.

Ports:
- Clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run; 0 = hold accumulator and counter at 0, no ticks.
- baud_select  in  3  table index 000..111 = 300/1200/4800/9600/19200/38400/57600/115200 baud.
- use_custom  in  1  1 = use custom_inc instead of the table.
- custom_inc  in  ACC_WIDTH  custom phase increment per clock.
- restart  in  1  synchronous realign pulse, driven by the RX start-bit detector.
- sample_tick  out  1  one-cycle pulse at OVERSAMPLE x baud rate.
- mid_bit_tick  out  1  one-cycle pulse at the bit centre.
- tx_tick  out  1  one-cycle pulse once per bit.
- sample_idx  out  log2(OVERSAMPLE)  current sample index within the bit.

Behaviour:
- Reset (reset=0, async): acc=0, sample_idx=0, all tick outputs 0, sel_q=0, custom_q=0.
- inc = use_custom ? custom_inc : TABLE[baud_select].
  - TABLE[b] = round(baud_b*OVERSAMPLE*2^ACC_WIDTH/CLK_FREQ_HZ), computed at elaboration.
  - Defaults: 115200 -> 618475; 9600 -> 51540; 300 -> 1611.
- Each clock with enable=1 and no clear: {carry,acc} <= acc + inc, computed ACC_WIDTH+1 wide; the carry is discarded after use.
- sample_tick is a register equal to carry. Latency: the tick is high in the cycle after the edge that overflowed.
- On a sample_tick cycle, sample_idx increments and wraps OVERSAMPLE-1 -> 0.
  - tx_tick = sample_tick AND sample_idx==OVERSAMPLE-1 (before the increment).
  - mid_bit_tick = sample_tick AND sample_idx==OVERSAMPLE/2-1.
  - All ticks are registered and aligned in the same cycle.
- Clear condition (synchronous, one cycle): restart=1, OR the {use_custom, baud_select, custom_inc when use_custom} snapshot differs from the registered copy.
  - Effect: acc<=0, sample_idx<=0, no tick that cycle; the snapshot register updates.
  - Clear beats a simultaneous carry: that tick is dropped.
- First tick after clear/enable with inc=I: sample_tick high after ceil(2^ACC_WIDTH/I) edges, i.e. one half-sample later than restart alignment requires? No: RX uses mid_bit_tick. After restart, the first mid_bit_tick falls OVERSAMPLE/2 sample periods later, which is the start-bit centre.
- enable=0: acc and sample_idx held at 0, ticks 0. On the re-enable edge, counting resumes from 0.
- inc=0: no ticks, no error.
- inc >= 2^ACC_WIDTH is not representable; max custom_inc = 2^ACC_WIDTH-1, which gives a tick on nearly every clock.
- Reset asserted mid-operation: all state zero immediately, asynchronously.
- Long-term tick rate = CLK_FREQ_HZ*inc/2^ACC_WIDTH, exact over each 2^ACC_WIDTH-cycle window. Cycle-to-cycle jitter is at most 1 clock.

Decomposition:
- Package uart_baud_pkg:
  - baud rate constants (BAUD_300..BAUD_115200);
  - 3-bit baud_sel encodings;
  - constant function baud_inc(baud, clk_hz, os, accw) returning the rounded increment.
- One natural sub-module, baud_phase_acc: accumulator + carry + clear/enable. The top holds the table mux, change detect, sample counter and tick decode.

Test Plan:
- Reset release, use_custom=1, custom_inc=2^22, ACC_WIDTH=24 -> sample_tick every 4 clocks; mid_bit_tick at sample_idx 7; tx_tick every 64 clocks; no ticks before the 4th edge.
- baud_select=111, table mode, run 2^24 clocks -> exactly 618475 sample_ticks and 38654 tx_ticks (618475/16, floor).
- restart pulse asserted in the same cycle as an expected carry -> that tick is suppressed. sample_idx=0 next cycle. Next sample_tick comes after a full sample period; first mid_bit_tick comes 8 sample ticks later.
- Change baud_select 011->111 mid-bit -> one-cycle clear; the new period, about 27.1 clocks average, starts from acc=0.
- enable=0 for 100 cycles mid-run -> no ticks, sample_idx=0. Re-enable -> first tick after ceil(2^24/inc) clocks.
- Assert reset asynchronously between clock edges with ticks active -> all outputs 0 immediately. After release, behaviour matches the first scenario.

Source files
------------

// File: rtl/uart_baud_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_baud_pkg
// Description : Baud-rate constants, table select encodings and the
//               elaboration-time phase-increment calculator for the
//               fractional UART baud-tick generator.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_baud_pkg;

    // Supported standard baud rates
    localparam int unsigned BAUD_300    = 300;
    localparam int unsigned BAUD_1200   = 1200;
    localparam int unsigned BAUD_4800   = 4800;
    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_38400  = 38400;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    // baud_select encodings
    localparam logic [2:0] SEL_300    = 3'b000;
    localparam logic [2:0] SEL_1200   = 3'b001;
    localparam logic [2:0] SEL_4800   = 3'b010;
    localparam logic [2:0] SEL_9600   = 3'b011;
    localparam logic [2:0] SEL_19200  = 3'b100;
    localparam logic [2:0] SEL_38400  = 3'b101;
    localparam logic [2:0] SEL_57600  = 3'b110;
    localparam logic [2:0] SEL_115200 = 3'b111;

    // Map a table index to its baud rate
    function automatic int unsigned baud_rate(input logic [2:0] sel);
        int unsigned rate;
        case (sel)
            SEL_300:    rate = BAUD_300;
            SEL_1200:   rate = BAUD_1200;
            SEL_4800:   rate = BAUD_4800;
            SEL_9600:   rate = BAUD_9600;
            SEL_19200:  rate = BAUD_19200;
            SEL_38400:  rate = BAUD_38400;
            SEL_57600:  rate = BAUD_57600;
            SEL_115200: rate = BAUD_115200;
            default:    rate = BAUD_115200;
        endcase
        return rate;
    endfunction

    // round(baud * os * 2^accw / clk_hz), evaluated in 64-bit integer math
    function automatic longint unsigned baud_inc(
        input longint unsigned baud,
        input longint unsigned clk_hz,
        input int unsigned     os,
        input int unsigned     accw
    );
        longint unsigned num;
        num = (baud * 64'(os)) << accw;
        return (num + (clk_hz / 2)) / clk_hz;
    endfunction

endpackage : uart_baud_pkg
`default_nettype wire

// File: rtl/baud_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : baud_phase_acc
// Description : NCO phase accumulator. Adds the phase increment every enabled
//               clock and exposes the overflow carry combinationally so the
//               parent can register all tick outputs in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_phase_acc #(
    parameter int ACC_WIDTH = 24
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [ACC_WIDTH-1:0] inc,
    output logic                 carry
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 run;

    // Next phase, one bit wider so the wrap shows up as the carry bit
    always_comb begin
        run   = enable & ~clear;
        sum   = {1'b0, acc} + {1'b0, inc};
        carry = run & sum[ACC_WIDTH];
    end

    // Phase register: forced to zero while disabled or on a clear cycle
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (run) begin
            acc <= sum[ACC_WIDTH-1:0];
        end else begin
            acc <= '0;
        end
    end

endmodule : baud_phase_acc
`default_nettype wire

// File: rtl/uart_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick_gen
// Description : Fractional (NCO based) UART baud-tick generator producing an
//               oversampled sample tick, a mid-bit strobe and a 1x TX tick.
//               Rate comes from an 8-entry baud table or a custom increment.
//               Any rate change or a restart pulse realigns the phase to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick_gen
    import uart_baud_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int OVERSAMPLE  = 16,        // power of two, 4..64
    parameter int ACC_WIDTH   = 24
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2:0]                    baud_select,
    input  logic                          use_custom,
    input  logic [ACC_WIDTH-1:0]          custom_inc,
    input  logic                          restart,
    output logic                          sample_tick,
    output logic                          mid_bit_tick,
    output logic                          tx_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] sample_idx
);

    localparam int IDX_W  = $clog2(OVERSAMPLE);
    localparam int SNAP_W = 1 + 3 + ACC_WIDTH;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(OVERSAMPLE / 2 - 1);

    logic [ACC_WIDTH-1:0] table_inc [8];
    logic [ACC_WIDTH-1:0] inc;
    logic [SNAP_W-1:0]    snap;
    logic [SNAP_W-1:0]    snap_q;
    logic                 clear;
    logic                 carry;

    // Baud table, every entry a constant resolved at elaboration
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_table
            localparam logic [ACC_WIDTH-1:0] ENTRY_INC = ACC_WIDTH'(
                baud_inc(64'(baud_rate(3'(gi))), 64'(CLK_FREQ_HZ),
                         OVERSAMPLE, ACC_WIDTH));
            assign table_inc[gi] = ENTRY_INC;
        end
    endgenerate

    // Increment select and rate-change detection; custom_inc only counts
    // as part of the configuration while it is actually in use
    always_comb begin
        inc   = use_custom ? custom_inc : table_inc[baud_select];
        snap  = {use_custom, baud_select, (use_custom ? custom_inc : {ACC_WIDTH{1'b0}})};
        clear = restart | (snap != snap_q);
    end

    // Configuration snapshot; after any change it differs for exactly one cycle
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap;
        end
    end

    baud_phase_acc #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_phase_acc (
        .Clk    (Clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .inc    (inc),
        .carry  (carry)
    );

    // Sample counter and tick decode; decode uses the pre-increment index
    // so all three ticks land in the same registered cycle
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sample_idx   <= '0;
            sample_tick  <= 1'b0;
            mid_bit_tick <= 1'b0;
            tx_tick      <= 1'b0;
        end else begin
            sample_tick  <= carry;
            mid_bit_tick <= carry && (sample_idx == MID_IDX);
            tx_tick      <= carry && (sample_idx == LAST_IDX);
            if (!enable || clear) begin
                sample_idx <= '0;
            end else if (carry) begin
                // power-of-two OVERSAMPLE: natural wrap LAST_IDX -> 0
                sample_idx <= sample_idx + 1'b1;
            end
        end
    end

endmodule : uart_baud_tick_gen
`default_nettype wire

// File: tb/tb_uart_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_baud_tick_gen
// Description : Self-checking bench for uart_baud_tick_gen with an arithmetic
//               reference model (tick k occurs when floor(n*inc/2^W) steps).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_tick_gen;

    localparam int CLK_HZ = 50000000;
    localparam int OS     = 16;
    localparam int ACCW   = 24;

    logic            Clk;
    logic            reset;
    logic            enable;
    logic [2:0]      baud_select;
    logic            use_custom;
    logic [ACCW-1:0] custom_inc;
    logic            restart;
    logic            sample_tick;
    logic            mid_bit_tick;
    logic            tx_tick;
    logic [3:0]      sample_idx;

    int checks = 0;
    int errors = 0;

    uart_baud_tick_gen #(
        .CLK_FREQ_HZ (CLK_HZ),
        .OVERSAMPLE  (OS),
        .ACC_WIDTH   (ACCW)
    ) dut (
        .Clk          (Clk),
        .reset        (reset),
        .enable       (enable),
        .baud_select  (baud_select),
        .use_custom   (use_custom),
        .custom_inc   (custom_inc),
        .restart      (restart),
        .sample_tick  (sample_tick),
        .mid_bit_tick (mid_bit_tick),
        .tx_tick      (tx_tick),
        .sample_idx   (sample_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    longint unsigned ref_table [8];
    initial begin
        int rates [8];
        rates = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
        for (int i = 0; i < 8; i++)
            ref_table[i] = longint'($rtoi(rates[i] * real'(OS) * (2.0 ** ACCW) / real'(CLK_HZ) + 0.5));
    end

    longint unsigned m_n;      // accumulations since last realign
    logic [27:0]     m_cfg;    // last seen configuration
    logic [3:0]      e_idx;
    logic            e_st, e_mid, e_tx;

    always @(posedge Clk or negedge reset) begin : model
        logic [27:0]     cfg;
        logic            realign;
        longint unsigned inc_now;
        logic            t;
        if (!reset) begin
            m_n <= 0; m_cfg <= '0; e_idx <= '0;
            e_st <= 1'b0; e_mid <= 1'b0; e_tx <= 1'b0;
        end else begin
            cfg     = {use_custom, baud_select, (use_custom ? custom_inc : 24'd0)};
            realign = restart || (cfg != m_cfg);
            inc_now = use_custom ? longint'(custom_inc) : ref_table[baud_select];
            m_cfg  <= cfg;
            if (!enable || realign) begin
                m_n <= 0; e_idx <= '0;
                e_st <= 1'b0; e_mid <= 1'b0; e_tx <= 1'b0;
            end else begin
                t = (((m_n + 1) * inc_now) >> ACCW) != ((m_n * inc_now) >> ACCW);
                m_n   <= m_n + 1;
                e_st  <= t;
                e_mid <= t && (int'(e_idx) == OS / 2 - 1);
                e_tx  <= t && (int'(e_idx) == OS - 1);
                if (t) e_idx <= 4'((int'(e_idx) + 1) % OS);
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; use_custom = 1'b0; baud_select = 3'd7;
        custom_inc = '0; restart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== 7'b0) begin
                errors++;
                $display("FAIL reset_state got st%b mid%b tx%b idx%0d want all 0",
                         sample_tick, mid_bit_tick, tx_tick, sample_idx);
            end
        end
    endtask

    task automatic test_custom_basic();
        int  j, txc;
        logic xt, xm, xx;
        logic [3:0] xi;
        reset = 1'b0; enable = 1'b1; use_custom = 1'b1; custom_inc = 24'h400000;
        baud_select = 3'd0; restart = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        txc = 0;
        // edge 1 realigns (config differs from reset copy); ticks from edge 5, every 4
        for (int e = 1; e <= 140; e++) begin
            cyc();
            j  = (e - 5) / 4;
            xt = (e >= 5) && ((e - 5) % 4 == 0);
            xm = xt && (j % OS == 7);
            xx = xt && (j % OS == OS - 1);
            xi = (e < 5) ? 4'd0 : 4'(((e - 5) / 4 + 1) % OS);
            if (tx_tick) txc++;
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== {xt, xm, xx, xi}) begin
                errors++;
                $display("FAIL custom_basic edge %0d got st%b mid%b tx%b idx%0d want st%b mid%b tx%b idx%0d",
                         e, sample_tick, mid_bit_tick, tx_tick, sample_idx, xt, xm, xx, xi);
            end
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== {e_st, e_mid, e_tx, e_idx}) begin
                errors++;
                $display("FAIL model_custom_basic edge %0d got %b%b%b/%0d want %b%b%b/%0d",
                         e, sample_tick, mid_bit_tick, tx_tick, sample_idx, e_st, e_mid, e_tx, e_idx);
            end
        end
        checks++;
        if (txc !== 2) begin
            errors++;
            $display("FAIL custom_tx_count got %0d want 2", txc);
        end
    endtask

    task automatic test_restart_collision();
        bit found;
        logic xt, xm;
        logic [3:0] xi;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc();
            if (sample_tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL restart_sync got no sample_tick want one within 8 cycles");
        end
        cyc(); cyc(); cyc();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        checks++;
        if (sample_tick !== 1'b0 || sample_idx !== 4'd0) begin
            errors++;
            $display("FAIL restart_drop got st%b idx%0d want st0 idx0", sample_tick, sample_idx);
        end
        for (int k = 1; k <= 36; k++) begin
            cyc();
            xt = (k % 4 == 0);
            xm = (k == 32);
            xi = 4'((k / 4) % OS);
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== {xt, xm, 1'b0, xi}) begin
                errors++;
                $display("FAIL restart_realign k %0d got st%b mid%b tx%b idx%0d want st%b mid%b tx0 idx%0d",
                         k, sample_tick, mid_bit_tick, tx_tick, sample_idx, xt, xm, xi);
            end
        end
    endtask

    task automatic test_baud_change();
        int sc, tc;
        longint unsigned exp_s;
        use_custom = 1'b0; baud_select = 3'd3;
        for (int i = 0; i < 400; i++) begin
            cyc();
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== {e_st, e_mid, e_tx, e_idx}) begin
                errors++;
                $display("FAIL model_baud9600 cyc %0d got %b%b%b/%0d want %b%b%b/%0d",
                         i, sample_tick, mid_bit_tick, tx_tick, sample_idx, e_st, e_mid, e_tx, e_idx);
            end
        end
        baud_select = 3'd7;
        cyc();
        checks++;
        if (sample_tick !== 1'b0 || sample_idx !== 4'd0) begin
            errors++;
            $display("FAIL baud_change_clear got st%b idx%0d want st0 idx0", sample_tick, sample_idx);
        end
        sc = 0; tc = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (sample_tick) sc++;
            if (tx_tick) tc++;
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== {e_st, e_mid, e_tx, e_idx}) begin
                errors++;
                $display("FAIL model_baud115200 cyc %0d got %b%b%b/%0d want %b%b%b/%0d",
                         i, sample_tick, mid_bit_tick, tx_tick, sample_idx, e_st, e_mid, e_tx, e_idx);
            end
        end
        exp_s = (2000 * ref_table[7]) >> ACCW;
        checks++;
        if (sc !== int'(exp_s) || tc !== int'(exp_s / OS)) begin
            errors++;
            $display("FAIL baud_change_count got s%0d t%0d want s%0d t%0d", sc, tc, exp_s, exp_s / OS);
        end
    endtask

    task automatic test_table_rate();
        int sc, tc, n;
        longint unsigned exp_s;
        int sels [2];
        sels = '{7, 4};
        for (int r = 0; r < 2; r++) begin
            baud_select = 3'(sels[r]);
            restart = 1'b1;
            cyc();
            restart = 1'b0;
            n  = (r == 0) ? 20000 : 10000;
            sc = 0; tc = 0;
            for (int i = 0; i < n; i++) begin
                cyc();
                if (sample_tick) sc++;
                if (tx_tick) tc++;
            end
            exp_s = (longint'(n) * ref_table[sels[r]]) >> ACCW;
            checks++;
            if (sc !== int'(exp_s) || tc !== int'(exp_s / OS)) begin
                errors++;
                $display("FAIL table_rate sel %0d got s%0d t%0d want s%0d t%0d",
                         sels[r], sc, tc, exp_s, exp_s / OS);
            end
        end
    endtask

    task automatic test_enable_hold();
        longint unsigned first;
        logic xt;
        use_custom = 1'b0; baud_select = 3'd7;
        for (int i = 0; i < 100; i++) cyc();
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== 7'b0) begin
                errors++;
                $display("FAIL enable_hold cyc %0d got st%b mid%b tx%b idx%0d want all 0",
                         i, sample_tick, mid_bit_tick, tx_tick, sample_idx);
            end
        end
        enable = 1'b1;
        first = ((64'd1 << ACCW) + ref_table[7] - 1) / ref_table[7];
        for (int e = 1; e <= 40; e++) begin
            cyc();
            xt = (longint'(e) == first);
            checks++;
            if (sample_tick !== xt || sample_idx !== ((longint'(e) >= first) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL reenable edge %0d got st%b idx%0d want st%b (first at %0d)",
                         e, sample_tick, sample_idx, xt, first);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        use_custom = 1'b1; custom_inc = 24'h400000;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (sample_tick) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL async_pre got no sample_tick want activity before reset");
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got st%b mid%b tx%b idx%0d want all 0",
                     sample_tick, mid_bit_tick, tx_tick, sample_idx);
        end
        test_custom_basic();
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            restart = ($urandom_range(0, 99) < 3);
            r = int'($urandom_range(0, 99));
            if (r < 2) enable = ~enable;
            else if (r < 4) begin
                use_custom  = $urandom_range(0, 1);
                baud_select = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0:       custom_inc = '0;
                    1:       custom_inc = 24'hFFFFFF;
                    default: custom_inc = 24'($urandom_range(32'h40000, 32'hFFFFFF));
                endcase
            end
            cyc();
            checks++;
            if ({sample_tick, mid_bit_tick, tx_tick, sample_idx} !== {e_st, e_mid, e_tx, e_idx}) begin
                errors++;
                $display("FAIL model_random cyc %0d got %b%b%b/%0d want %b%b%b/%0d",
                         i, sample_tick, mid_bit_tick, tx_tick, sample_idx, e_st, e_mid, e_tx, e_idx);
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; baud_select = '0; use_custom = 1'b0;
        custom_inc = '0; restart = 1'b0;
        test_reset();
        test_custom_basic();
        test_restart_collision();
        test_baud_change();
        test_table_rate();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_baud_tick_gen
`default_nettype wire
